// File: rtl/jtopl_eg_cfg_if.sv
// CPU-side bus of the envelope configuration block: OPL2-style address/data
// write port plus the busy flag that reports a pending commit.
interface jtopl_eg_cfg_if;
   logic       cs_n;
   logic       wr_n;
   logic       a0;
   logic [7:0] din;
   logic       busy;

   modport master (
      output cs_n,
      output wr_n,
      output a0,
      output din,
      input  busy
   );

   modport slave (
      input  cs_n,
      input  wr_n,
      input  a0,
      input  din,
      output busy
   );
endinterface

// File: rtl/jtopl_eg_cfg.sv
// Envelope-configuration register file and slot sequencer. CPU writes are
// buffered and committed on an operator-rate enable so the per-slot stream
// seen by the envelope generator never changes between slots.
module jtopl_eg_cfg #(
   parameter int unsigned SLOTS = 18
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cenop,
   jtopl_eg_cfg_if.slave       cpu,
   output logic                zero,
   output logic [4:0]          slot,
   output logic                en_sus_I,
   output logic                ksr_I,
   output logic [3:0]          arate_I,
   output logic [3:0]          drate_I,
   output logic [3:0]          rrate_I,
   output logic [3:0]          sl_I,
   output logic                keyon_I
);

   if (SLOTS != 18) begin : g_bad_slots
      $error("jtopl_eg_cfg supports only SLOTS = 18");
   end

   // Channel served by a slot: slots s and s+3 of each group of six pair up.
   function automatic logic [3:0] chan_of(input logic [4:0] s);
      logic [4:0] g;
      logic [4:0] r;
      g = s / 5'd6;
      r = s - g * 5'd6;
      return 4'(g * 5'd3 + r % 5'd3);
   endfunction

   logic             req, req_q, ev_q, a0_q;
   logic [7:0]       din_q, addr_q, buf_addr, buf_dat;
   logic             busy_q, commit, op_valid;
   logic [4:0]       dec_slot, slot_nx;

   logic [SLOTS-1:0][3:0] ar_q, ar_d, dr_q, dr_d, sl_q, sl_d, rr_q, rr_d;
   logic [SLOTS-1:0]      egt_q, egt_d, ksr_q, ksr_d;
   logic [8:0]            keyon_q, keyon_d;

   assign req      = ~cpu.cs_n & ~cpu.wr_n;
   assign cpu.busy = busy_q;
   assign commit   = cenop & busy_q;
   assign op_valid = (buf_addr[2:0] < 3'd6) && (buf_addr[4:3] != 2'b11);
   assign dec_slot = {3'b000, buf_addr[4:3]} * 5'd6 + {2'b00, buf_addr[2:0]};
   assign slot_nx  = (slot == 5'd17) ? 5'd0 : slot + 5'd1;

   // Strobe edge detection: one event per write strobe, with bus values captured alongside.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q <= 1'b0;
         ev_q  <= 1'b0;
         a0_q  <= 1'b0;
         din_q <= 8'h00;
      end else begin
         req_q <= req;
         ev_q  <= req & ~req_q;
         a0_q  <= cpu.a0;
         din_q <= cpu.din;
      end
   end

   // Address latch and single-entry write buffer; the first data write wins until commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= 8'h00;
         buf_addr <= 8'h00;
         buf_dat  <= 8'h00;
         busy_q   <= 1'b0;
      end else begin
         if (ev_q && !a0_q) addr_q <= din_q;
         if (commit) begin
            busy_q <= 1'b0;
         end else if (ev_q && a0_q && !busy_q) begin
            buf_addr <= addr_q;
            buf_dat  <= din_q;
            busy_q   <= 1'b1;
         end
      end
   end

   // Next storage contents: decode of the buffered write on a commit edge.
   always_comb begin
      ar_d    = ar_q;
      dr_d    = dr_q;
      sl_d    = sl_q;
      rr_d    = rr_q;
      egt_d   = egt_q;
      ksr_d   = ksr_q;
      keyon_d = keyon_q;
      if (commit && op_valid) begin
         case (buf_addr[7:5])
            3'b001: begin
               egt_d[dec_slot] = buf_dat[5];
               ksr_d[dec_slot] = buf_dat[4];
            end
            3'b011: begin
               ar_d[dec_slot] = buf_dat[7:4];
               dr_d[dec_slot] = buf_dat[3:0];
            end
            3'b100: begin
               sl_d[dec_slot] = buf_dat[7:4];
               rr_d[dec_slot] = buf_dat[3:0];
            end
            default: ;
         endcase
      end
      if (commit && buf_addr[7:4] == 4'hB && buf_addr[3:0] <= 4'd8) begin
         keyon_d[buf_addr[3:0]] = buf_dat[5];
      end
   end

   // Storage registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ar_q    <= '0;
         dr_q    <= '0;
         sl_q    <= '0;
         rr_q    <= '0;
         egt_q   <= '0;
         ksr_q   <= '0;
         keyon_q <= '0;
      end else begin
         ar_q    <= ar_d;
         dr_q    <= dr_d;
         sl_q    <= sl_d;
         rr_q    <= rr_d;
         egt_q   <= egt_d;
         ksr_q   <= ksr_d;
         keyon_q <= keyon_d;
      end
   end

   // Slot sequencer; outputs read the post-commit contents so a same-edge write is visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot     <= 5'd0;
         zero     <= 1'b1;
         en_sus_I <= 1'b0;
         ksr_I    <= 1'b0;
         arate_I  <= 4'h0;
         drate_I  <= 4'h0;
         rrate_I  <= 4'h0;
         sl_I     <= 4'h0;
         keyon_I  <= 1'b0;
      end else if (cenop) begin
         slot     <= slot_nx;
         zero     <= (slot_nx == 5'd0);
         en_sus_I <= egt_d[slot_nx];
         ksr_I    <= ksr_d[slot_nx];
         arate_I  <= ar_d[slot_nx];
         drate_I  <= dr_d[slot_nx];
         rrate_I  <= rr_d[slot_nx];
         sl_I     <= sl_d[slot_nx];
         keyon_I  <= keyon_d[chan_of(slot_nx)];
      end
   end

endmodule

// File: tb/tb_jtopl_eg_cfg.sv
// Scoreboard bench: the stimulus side updates a register-level model of the
// slot configuration and queues the expected per-slot output for every cenop;
// an independent monitor pops and compares after each cenop edge.
module tb_jtopl_eg_cfg;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cenop = 1'b0;
   logic       zero, en_sus_I, ksr_I, keyon_I;
   logic [4:0] slot;
   logic [3:0] arate_I, drate_I, rrate_I, sl_I;

   jtopl_eg_cfg_if cpu_if ();

   jtopl_eg_cfg #(.SLOTS(18)) dut (
      .clk      (clk),
      .rst      (rst),
      .cenop    (cenop),
      .cpu      (cpu_if),
      .zero     (zero),
      .slot     (slot),
      .en_sus_I (en_sus_I),
      .ksr_I    (ksr_I),
      .arate_I  (arate_I),
      .drate_I  (drate_I),
      .rrate_I  (rrate_I),
      .sl_I     (sl_I),
      .keyon_I  (keyon_I)
   );

   always #5 clk = ~clk;

   typedef struct {
      int slot; int zero; int egt; int ksr; int ar; int dr; int sl; int rr; int ko;
   } exp_t;

   exp_t q[$];
   int n_pass = 0;
   int n_total = 0;

   // Reference model of the register file
   int m_ar[18], m_dr[18], m_sl[18], m_rr[18], m_egt[18], m_ksr[18], m_ko[9];
   int m_slot, m_addr, m_baddr, m_bdat;
   bit m_busy;

   function automatic void model_reset();
      for (int i = 0; i < 18; i++) begin
         m_ar[i] = 0; m_dr[i] = 0; m_sl[i] = 0; m_rr[i] = 0; m_egt[i] = 0; m_ksr[i] = 0;
      end
      for (int i = 0; i < 9; i++) m_ko[i] = 0;
      m_slot = 0; m_addr = 0; m_baddr = 0; m_bdat = 0; m_busy = 0;
   endfunction

   function automatic int chan(int s);
      return (s / 6) * 3 + (s % 6) % 3;
   endfunction

   function automatic void model_commit(int a, int d);
      int o, s;
      if (a >= 'hB0 && a <= 'hB8) begin
         m_ko[a - 'hB0] = (d >> 5) & 1;
      end else begin
         o = a & 31;
         if ((o % 8) < 6 && o < 22) begin
            s = (o / 8) * 6 + (o % 8);
            if (a >= 'h20 && a <= 'h35) begin
               m_egt[s] = (d >> 5) & 1;
               m_ksr[s] = (d >> 4) & 1;
            end else if (a >= 'h60 && a <= 'h75) begin
               m_ar[s] = d / 16;
               m_dr[s] = d % 16;
            end else if (a >= 'h80 && a <= 'h95) begin
               m_sl[s] = d / 16;
               m_rr[s] = d % 16;
            end
         end
      end
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: every cenop edge presents a new slot; compare against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (rst && cenop) begin
            @(negedge clk);
            if (q.size() == 0) begin
               check("queue_underflow", 1, 0);
            end else begin
               e = q.pop_front();
               check("slot", int'(slot), e.slot);
               check("zero", int'(zero), e.zero);
               check("en_sus_I", int'(en_sus_I), e.egt);
               check("ksr_I", int'(ksr_I), e.ksr);
               check("arate_I", int'(arate_I), e.ar);
               check("drate_I", int'(drate_I), e.dr);
               check("sl_I", int'(sl_I), e.sl);
               check("rrate_I", int'(rrate_I), e.rr);
               check("keyon_I", int'(keyon_I), e.ko);
            end
         end
      end
   end

   task automatic do_cenop();
      exp_t e;
      @(negedge clk);
      if (m_busy) begin
         model_commit(m_baddr, m_bdat);
         m_busy = 0;
      end
      m_slot = (m_slot + 1) % 18;
      e.slot = m_slot; e.zero = (m_slot == 0) ? 1 : 0;
      e.egt = m_egt[m_slot]; e.ksr = m_ksr[m_slot];
      e.ar = m_ar[m_slot]; e.dr = m_dr[m_slot];
      e.sl = m_sl[m_slot]; e.rr = m_rr[m_slot];
      e.ko = m_ko[chan(m_slot)];
      q.push_back(e);
      cenop = 1'b1;
      @(negedge clk);
      cenop = 1'b0;
      check("busy_after_cenop", int'(cpu_if.busy), 0);
   endtask

   task automatic cenops(input int n);
      for (int i = 0; i < n; i++) do_cenop();
   endtask

   task automatic wr(input bit a0, input int d);
      int len;
      len = $urandom_range(1, 4);
      @(negedge clk);
      cpu_if.cs_n = 1'b0;
      cpu_if.wr_n = 1'b0;
      cpu_if.a0   = a0;
      cpu_if.din  = 8'(d);
      repeat (len) @(negedge clk);
      cpu_if.cs_n = 1'b1;
      cpu_if.wr_n = 1'b1;
      cpu_if.din  = 8'($urandom);
      repeat (2) @(negedge clk);
      if (!a0) m_addr = d;
      else if (!m_busy) begin
         m_busy = 1; m_baddr = m_addr; m_bdat = d;
      end
      check("busy_after_write", int'(cpu_if.busy), int'(m_busy));
   endtask

   task automatic wreg(input int a, input int d);
      wr(1'b0, a);
      wr(1'b1, d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      check("rst_slot", int'(slot), 0);
      check("rst_zero", int'(zero), 1);
      check("rst_busy", int'(cpu_if.busy), 0);
      check("rst_cfg", int'({en_sus_I, ksr_I, arate_I, drate_I, rrate_I, sl_I, keyon_I}), 0);
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, d;
      cpu_if.cs_n = 1'b1;
      cpu_if.wr_n = 1'b1;
      cpu_if.a0   = 1'b0;
      cpu_if.din  = 8'h00;
      model_reset();
      do_reset();

      // Reset mid-sequence and mid-write: pending data must be dropped
      cenops(5);
      wreg('h60, 'hFF);
      do_reset();
      cenops(18);

      wreg('h68, 'hA5);
      cenops(18);
      wreg('h93, 'h7C);
      cenops(18);
      wreg('h86, 'hFF);
      cenops(18);
      wreg('hB4, 'h20);
      cenops(18);
      wreg('hB4, 'h00);
      cenops(18);
      wreg('h60, 'h11);
      wreg('h60, 'h22);
      cenops(18);

      // Commit lands on the edge that loads slot 3
      while (m_slot != 2) do_cenop();
      wreg('h23, 'h30);
      do_cenop();
      cenops(18);

      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 3))
            0: cenops($urandom_range(1, 6));
            3: wr(1'b1, $urandom_range(0, 255));
            default: begin
               case ($urandom_range(0, 4))
                  0: a = 'h20 + $urandom_range(0, 31);
                  1: a = 'h60 + $urandom_range(0, 31);
                  2: a = 'h80 + $urandom_range(0, 31);
                  3: a = 'hB0 + $urandom_range(0, 15);
                  default: a = $urandom_range(0, 255);
               endcase
               d = $urandom_range(0, 255);
               wreg(a, d);
            end
         endcase
      end
      cenops(18);
      do_reset();
      cenops(18);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
